// File: rtl/serial_shift_unit.sv
// serial_shift_unit
//   Bit-serial shifter: applies one single-position shift per clock until the
//   requested offset (clamped to WIDTH) has been consumed. Supports left
//   logical/arithmetic and right logical/arithmetic shifts.
//
//   Handshake: a request is accepted on any rising edge where the unit is
//   idle or finishing (IDLE or DONE) and start=1. busy is high for every
//   SHIFT cycle, done pulses for exactly one cycle when the result is ready,
//   and data_out/shifted_out hold the result until the next accepted start.
//   start is ignored (not queued) while busy.
//
// Ports:
//   clk         - clock, rising-edge active
//   rst         - synchronous active-high reset (priority over start)
//   start       - operation request
//   op          - 00 LLS, 01 LAS, 10 RLS, 11 RAS
//   data_in     - operand word
//   offset      - unsigned shift distance
//   busy        - high while shifting
//   done        - one-cycle completion pulse
//   data_out    - shift result (working register)
//   shifted_out - last bit pushed out of the word, 0 if no shift occurred
module serial_shift_unit #(
    parameter int WIDTH = 16,
    parameter int OFFW  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [OFFW-1:0]  offset,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out,
    output logic             shifted_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // WIDTH always fits in OFFW bits because 2**(OFFW-1) == WIDTH.
    localparam logic [OFFW-1:0] WIDTH_OFF = OFFW'(WIDTH);

    state_t          state;
    logic [OFFW-1:0] count;
    logic [OFFW-1:0] start_count;
    logic [1:0]      op_q;
    logic            sign;

    // Offsets beyond the word width behave exactly like a full-width shift.
    always_comb begin
        start_count = offset;
        if (offset >= WIDTH_OFF) begin
            start_count = WIDTH_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            data_out    <= '0;
            shifted_out <= 1'b0;
            count       <= '0;
            op_q        <= 2'b00;
            sign        <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        op_q        <= op;
                        data_out    <= data_in;
                        sign        <= data_in[WIDTH-1];
                        shifted_out <= 1'b0;
                        count       <= start_count;
                        if (start_count != '0) begin
                            state <= SHIFT;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end else begin
                            // Zero-distance request completes immediately.
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end

                SHIFT: begin
                    if (!op_q[1]) begin
                        // LLS and LAS are bit-identical.
                        data_out    <= {data_out[WIDTH-2:0], 1'b0};
                        shifted_out <= data_out[WIDTH-1];
                    end else begin
                        // RAS refills with the sign captured at accept time.
                        data_out    <= {(op_q[0] & sign), data_out[WIDTH-1:1]};
                        shifted_out <= data_out[0];
                    end
                    count <= count - 1'b1;
                    if (count == OFFW'(1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
